// File: rtl/key_dir_ctrl.sv
// key_dir_ctrl: debounced direction/speed keys driving a rotating-LED step strobe.
// Ports: clk, rst (async, active-high), key_dir_n/key_spd_n (active-low async keys),
//        sentido (1 = toward index 0), step (one-cycle strobe), spd (speed 0..3).
// Optional macro KEY_DIR_CTRL_AUTOREV_EN: flip sentido after every 10th step.
module key_dir_ctrl #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int STEP_BASE  = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_dir_n,
  input  logic       key_spd_n,
  output logic       sentido,
  output logic       step,
  output logic [1:0] spd
);
  localparam int SW = $clog2(STEP_BASE);
  localparam int DW = $clog2(DEB_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, PRESS_CHK, PRESSED, REL_CHK} deb_t;
  logic [1:0] key_n, sync1_q, sync1_d, sync2_q, sync2_d, press;
  assign key_n = {key_spd_n, key_dir_n};
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  for (genvar k = 0; k < 2; k++) begin : g_deb
    deb_t state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic low, done, ev;
    assign low  = ~sync2_q[k];
    assign done = cnt_q == DW'(DEB_CYCLES - 1);
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE:      state_d = low ? PRESS_CHK : IDLE;
        PRESS_CHK: state_d = !low ? IDLE : done ? PRESSED : PRESS_CHK;
        PRESSED:   state_d = low ? PRESSED : REL_CHK;
        REL_CHK:   state_d = low ? PRESSED : done ? IDLE : REL_CHK;
        default:   state_d = IDLE;
      endcase
      // any transition restarts the count, so a bounce costs a full DEB_CYCLES again
      cnt_d = (state_d != state_q || state_q == IDLE || state_q == PRESSED) ? '0 : cnt_q + 1'b1;
    end
    always_comb ev = state_q == PRESS_CHK && state_d == PRESSED;
    assign press[k] = ev;
  end
  logic [SW-1:0] cnt_q, cnt_d;
  logic [1:0]    spd_q, spd_d;
  logic          sentido_q, sentido_d;
  logic [31:0]   per_m1;
`ifdef KEY_DIR_CTRL_AUTOREV_EN
  logic [3:0] tally_q, tally_d;
  logic       tenth;
`endif
  always_comb begin
    per_m1 = (32'(STEP_BASE) >> spd_q) - 32'd1;
    step   = 32'(cnt_q) == per_m1;
    cnt_d  = (press[1] | step) ? '0 : cnt_q + 1'b1;
    spd_d  = spd_q + 2'(press[1]);
`ifdef KEY_DIR_CTRL_AUTOREV_EN
    tenth     = step && tally_q == 4'd9;
    tally_d   = (press[0] | tenth) ? '0 : tally_q + 4'(step);
    sentido_d = sentido_q ^ (press[0] | tenth);
`else
    sentido_d = sentido_q ^ press[0];
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q     <= '0;
      spd_q     <= '0;
      sentido_q <= 1'b0;
`ifdef KEY_DIR_CTRL_AUTOREV_EN
      tally_q   <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      spd_q     <= spd_d;
      sentido_q <= sentido_d;
`ifdef KEY_DIR_CTRL_AUTOREV_EN
      tally_q   <= tally_d;
`endif
    end
  assign sentido = sentido_q;
  assign spd     = spd_q;
endmodule

// File: tb/tb_key_dir_ctrl.sv
// tb_key_dir_ctrl: directed plus random key stimulus against a run-length reference model.
module tb_key_dir_ctrl;
  localparam int DEB = 4;
  localparam int SB  = 16;
  logic clk = 0, rst = 0, key_dir_n = 1, key_spd_n = 1;
  logic sentido, step;
  logic [1:0] spd;
  int vecs = 0, errs = 0;
  bit m_sen;
  int m_spd, m_cnt, m_tally;
  bit p1[2], p2[2], pressed[2];
  int run[2];
  key_dir_ctrl #(.DEB_CYCLES(DEB), .STEP_BASE(SB)) dut (
    .clk(clk), .rst(rst), .key_dir_n(key_dir_n), .key_spd_n(key_spd_n),
    .sentido(sentido), .step(step), .spd(spd)
  );
  always #5 clk = ~clk;
  function void m_reset();
    m_sen = 0; m_spd = 0; m_cnt = 0; m_tally = 0;
    for (int k = 0; k < 2; k++) begin
      p1[k] = 1; p2[k] = 1; pressed[k] = 0; run[k] = 0;
    end
  endfunction
  function bit exp_step();
    return m_cnt == (SB >> m_spd) - 1;
  endfunction
  // A key changes its accepted level once the synchronized input has disagreed
  // with it for DEB+1 samples in a row (one to leave the stable state, DEB to qualify).
  function void m_edge();
    bit ev[2];
    bit kin[2];
    bit lo;
`ifdef KEY_DIR_CTRL_AUTOREV_EN
    bit st;
    st = exp_step();
`endif
    kin[0] = key_dir_n; kin[1] = key_spd_n;
    for (int k = 0; k < 2; k++) begin
      ev[k] = 0;
      lo = !p2[k];
      if (lo != pressed[k]) run[k]++; else run[k] = 0;
      if (run[k] == DEB + 1) begin
        pressed[k] = lo; run[k] = 0; ev[k] = lo;
      end
      p2[k] = p1[k]; p1[k] = kin[k];
    end
`ifdef KEY_DIR_CTRL_AUTOREV_EN
    if (ev[0]) begin m_sen = !m_sen; m_tally = 0; end
    else if (st) begin
      m_tally++;
      if (m_tally == 10) begin m_sen = !m_sen; m_tally = 0; end
    end
`else
    if (ev[0]) m_sen = !m_sen;
`endif
    if (ev[1]) begin m_spd = (m_spd + 1) % 4; m_cnt = 0; end
    else m_cnt = (m_cnt + 1) % (SB >> m_spd);
  endfunction
  task check();
    vecs++;
    assert (sentido === m_sen) else begin errs++; $error("FAIL sentido got %0b exp %0b t=%0t", sentido, m_sen, $time); end
    vecs++;
    assert (step === exp_step()) else begin errs++; $error("FAIL step got %0b exp %0b t=%0t", step, exp_step(), $time); end
    vecs++;
    assert (spd === 2'(m_spd)) else begin errs++; $error("FAIL spd got %0d exp %0d t=%0t", spd, m_spd, $time); end
  endtask
  task tick();
    @(posedge clk);
    if (rst) m_reset(); else m_edge();
    #1 check();
  endtask
  task ticks(input int n);
    repeat (n) tick();
  endtask
  initial begin
    #2 rst = 1;
    #1 m_reset();
    check();
    ticks(2);
    rst = 0;
    ticks(40);
    repeat (3) begin
      key_dir_n = 0; ticks(3);
      key_dir_n = 1; ticks(3);
    end
    key_dir_n = 0; ticks(20);
    key_dir_n = 1; ticks(20);
    repeat (4) begin
      key_spd_n = 0; ticks(8);
      key_spd_n = 1; ticks(24);
    end
    key_dir_n = 0; ticks(2);
    rst = 1;
    #1 m_reset();
    check();
    ticks(2);
    rst = 0;
    ticks(12);
    key_dir_n = 1; ticks(10);
    key_dir_n = 0; key_spd_n = 0; ticks(8);
    key_dir_n = 1; key_spd_n = 1; ticks(10);
    repeat (2) begin
      key_spd_n = 0; ticks(8);
      key_spd_n = 1; ticks(10);
    end
    ticks(60);
    repeat (80) begin
      key_dir_n = 1'($urandom_range(0, 1));
      key_spd_n = 1'($urandom_range(0, 1));
      ticks(int'($urandom_range(1, 9)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/key_dir_ctrl.md
KEY_DIR_CTRL -- requirements
Module: key_dir_ctrl

Interface
REQ-001 The block SHALL provide parameter DEB_CYCLES, default 1_000_000, meaning the number of stable cycles a key must hold to be accepted (20 ms at 50 MHz).
REQ-002 The block SHALL provide parameter STEP_BASE, default 25_000_000, meaning the step period in clk cycles at speed 0.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 key_dir_n  input  1  direction pushbutton, active-low, asynchronous to clk.
REQ-006 key_spd_n  input  1  speed pushbutton, active-low, asynchronous to clk.
REQ-007 sentido  output  1  rotation direction to the PWM LED stage: 1 = shift toward index 0, 0 = toward index 9.
REQ-008 step  output  1  single-cycle rotation strobe to the PWM LED stage.
REQ-009 spd  output  2  current speed level 0..3.

Function
REQ-010 Each key SHALL pass through a two-flop synchronizer before any other logic; the synchronizer adds 2 cycles of latency.
REQ-011 Each key SHALL have its own debounce FSM with states IDLE, PRESS_CHK, PRESSED, REL_CHK.
REQ-012 IDLE -> PRESS_CHK on synchronized low; PRESS_CHK -> PRESSED after DEB_CYCLES consecutive low samples; PRESS_CHK -> IDLE on any high sample.
REQ-013 PRESSED -> REL_CHK on synchronized high; REL_CHK -> IDLE after DEB_CYCLES consecutive high samples; REL_CHK -> PRESSED on any low sample.
REQ-014 The debounce counter SHALL clear on every state transition, so a bounce restarts the full count.
REQ-015 The PRESS_CHK -> PRESSED transition SHALL generate exactly one press event of one cycle; a held key SHALL NOT generate further events.
REQ-016 A dir press event SHALL toggle sentido on the following clock edge.
REQ-017 A spd press event SHALL increment spd modulo 4 (3 wraps to 0) and clear the step counter in the same edge.
REQ-018 Step period SHALL be STEP_BASE >> spd cycles: 25M, 12.5M, 6.25M, 3.125M at default.
REQ-019 The step counter SHALL count 0 .. period-1; step SHALL be 1 in the cycle in which the count equals period-1, and the counter then wraps to 0.
REQ-020 Counter width SHALL be $clog2(STEP_BASE); the period comparison SHALL use the full counter width with no truncation.
REQ-021 Dir and spd events arriving in the same cycle SHALL both take effect.
REQ-022 A dir press SHALL NOT alter the step counter or the step timing.

Reset
REQ-023 Asserting rst SHALL force sentido=0, step=0, spd=0, both FSMs to IDLE, and all counters and synchronizer flops to their released/zero values immediately.
REQ-024 Reset asserted mid-debounce SHALL discard the pending press; no event SHALL follow deassertion unless the key is re-qualified from IDLE.
REQ-025 The first step after reset deassertion SHALL occur STEP_BASE cycles after the first active edge.

Configuration
REQ-026 With macro KEY_DIR_CTRL_AUTOREV_EN defined, a 4-bit step tally SHALL count step pulses and toggle sentido after every 10th step, then clear.
REQ-027 With KEY_DIR_CTRL_AUTOREV_EN defined, a dir press SHALL clear the tally; if a dir press and the 10th step coincide, sentido SHALL toggle once only and the tally SHALL clear.
REQ-028 Without KEY_DIR_CTRL_AUTOREV_EN, no tally logic SHALL exist and sentido SHALL change only on dir press events.

Verification (DEB_CYCLES=4, STEP_BASE=16)
REQ-029 Reset, then idle for 40 cycles -> step pulses at cycles 16 and 32 after reset release; sentido=0; spd=0.
REQ-030 Hold key_dir_n low for 10 cycles with 3-cycle bounces first, then hold low for 20 cycles -> exactly one toggle of sentido; no toggle during the bounces.
REQ-031 Press key_spd_n 4 times -> spd goes 1,2,3,0; step periods become 8,4,2,16; the step counter restarts at each press.
REQ-032 Assert rst while key_dir_n has been low for 2 cycles -> after release sentido=0 and no toggle occurs until a fresh 4-cycle low qualifies.
REQ-033 With KEY_DIR_CTRL_AUTOREV_EN at spd=3 -> sentido toggles after every 10 steps (every 20 cycles); a dir press coincident with the 10th step gives a single toggle.
REQ-034 Apply dir and spd presses in the same cycle -> sentido toggles and spd increments on the same edge.
